// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared address constants, address type and next-PC state encoding
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int PC_INC = 1;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } npc_state_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - parameterised LIFO of return addresses with level/full/empty status
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] level_m1;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign level_m1 = level - LW'(1);
  // Empty reads as zero so an unguarded consumer never sees stale data.
  assign top      = empty ? '0 : mem[level_m1[IW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[level[IW-1:0]] <= push_data;
      level              <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= level_m1;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - combinational next-PC selection with return stack and RUN/HALTED/FAULT control
module next_pc_unit #(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int PC_INC      = cpu_pkg::PC_INC,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [ADDR_W-1:0]              pc_in,
  input  logic                           stall,
  input  logic                           br_taken,
  input  logic [ADDR_W-1:0]              br_off,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           halt,
  output logic [ADDR_W-1:0]              next_pc,
  output logic [$clog2(STACK_DEPTH):0]   sp_level,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           halted,
  output logic                           fault
);

  import cpu_pkg::*;

  npc_state_t        state, state_d;
  logic              push, pop;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc_seq;

  // Return address and sequential successor are the same value.
  assign pc_seq = pc_in + ADDR_W'(PC_INC);

  always_comb begin
    next_pc = pc_in;
    push    = 1'b0;
    pop     = 1'b0;
    state_d = state;
    if (clr) begin
      next_pc = '0;
    end else if (state == RUN) begin
      if (halt) begin
        state_d = HALTED;
      end else if (stall) begin
        next_pc = pc_in;
      end else if (ret) begin
        if (!stack_empty) begin
          next_pc = stack_top;
          pop     = 1'b1;
        end else begin
          state_d = FAULT;
        end
      end else if (call) begin
        if (!stack_full) begin
          next_pc = target;
          push    = 1'b1;
        end else begin
          state_d = FAULT;
        end
      end else if (jump) begin
        next_pc = target;
      end else if (br_taken) begin
        next_pc = pc_in + br_off;
      end else begin
        next_pc = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= RUN;
    else     state <= state_d;
  end

  assign halted = (state == HALTED);
  assign fault  = (state == FAULT);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (stack_top),
    .level     (sp_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed self-checking bench for next_pc_unit
module tb_next_pc_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] pc_in;
  logic       stall, br_taken, jump, call, ret, halt;
  logic [7:0] br_off, target;
  logic [7:0] next_pc;
  logic [2:0] sp_level;
  logic       stack_full, stack_empty, halted, fault;

  int checks   = 0;
  int failures = 0;
  logic [7:0] pc_q;

  next_pc_unit #(.ADDR_W(8), .PC_INC(1), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .pc_in       (pc_in),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_off      (br_off),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .halt        (halt),
    .next_pc     (next_pc),
    .sp_level    (sp_level),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jump = 0; call = 0; ret = 0; halt = 0;
    br_off = 8'h00; target = 8'h00;
  endtask

  task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt, input logic [7:0] exp_npc);
    idle(); pc_in = pc; call = 1; target = tgt;
    #1 check("call_npc", 32'(next_pc), 32'(exp_npc));
    step();
    idle();
  endtask

  task automatic do_ret(input logic [7:0] pc, input logic [7:0] exp_npc);
    idle(); pc_in = pc; ret = 1;
    #1 check("ret_npc", 32'(next_pc), 32'(exp_npc));
    step();
    idle();
  endtask

  initial begin
    idle();
    clr = 1; pc_in = 8'h55; jump = 1; target = 8'h77;
    #1 check("clr_npc_forced_zero", 32'(next_pc), 32'h00);
    step();
    check("clr_npc_cycle2", 32'(next_pc), 32'h00);
    step();
    check("rst_sp_level", 32'(sp_level), 0);
    check("rst_empty", 32'(stack_empty), 1);
    check("rst_full", 32'(stack_full), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);

    // Free-run against a program_counter model that was cleared to zero.
    idle(); clr = 0; pc_q = 8'h00;
    for (int i = 0; i < 5; i++) begin
      pc_in = pc_q;
      #1 check("seq_pc_in", 32'(pc_in), 32'(i));
      check("seq_npc", 32'(next_pc), 32'(i + 1));
      check("seq_empty", 32'(stack_empty), 1);
      pc_q = next_pc;
      step();
    end

    pc_in = 8'hFF;
    #1 check("wrap_ff", 32'(next_pc), 32'h00);
    pc_in = 8'h10; br_taken = 1; br_off = 8'hFC;
    #1 check("branch_back", 32'(next_pc), 32'h0C);
    pc_in = 8'hFE; br_off = 8'h05;
    #1 check("branch_wrap", 32'(next_pc), 32'h03);
    idle(); pc_in = 8'h10; jump = 1; target = 8'h70; br_taken = 1; br_off = 8'h01;
    #1 check("jump_over_branch", 32'(next_pc), 32'h70);
    step(); idle();

    do_call(8'h05, 8'h40, 8'h40);
    check("nest_sp1", 32'(sp_level), 1);
    do_call(8'h42, 8'h80, 8'h80);
    check("nest_sp2", 32'(sp_level), 2);
    do_ret(8'h80, 8'h43);
    check("nest_ret_sp1", 32'(sp_level), 1);
    do_ret(8'h44, 8'h06);
    check("nest_ret_sp0", 32'(sp_level), 0);
    check("nest_empty", 32'(stack_empty), 1);

    pc_in = 8'h33; stall = 1; call = 1; jump = 1; target = 8'h99;
    #1 check("stall_prio_npc", 32'(next_pc), 32'h33);
    step(); idle();
    check("stall_prio_sp", 32'(sp_level), 0);

    // Fill, pop the newest, refill, then overflow.
    do_call(8'h00, 8'hA0, 8'hA0);
    do_call(8'h10, 8'hA1, 8'hA1);
    do_call(8'h20, 8'hA2, 8'hA2);
    do_call(8'h30, 8'hA3, 8'hA3);
    check("fill_sp4", 32'(sp_level), 4);
    check("fill_full", 32'(stack_full), 1);
    do_ret(8'hA3, 8'h31);
    check("fill_pop_sp3", 32'(sp_level), 3);
    do_call(8'h3A, 8'hA4, 8'hA4);
    check("refill_full", 32'(stack_full), 1);
    pc_in = 8'h20; call = 1; target = 8'h90;
    #1 check("ovf_npc", 32'(next_pc), 32'h20);
    step(); idle();
    check("ovf_fault", 32'(fault), 1);
    check("ovf_sp4", 32'(sp_level), 4);
    pc_in = 8'h21; jump = 1; target = 8'h50;
    #1 check("fault_jump_ignored", 32'(next_pc), 32'h21);
    step(); idle();
    pc_in = 8'h21; ret = 1;
    #1 check("fault_ret_ignored", 32'(next_pc), 32'h21);
    step(); idle();
    check("fault_sp_frozen", 32'(sp_level), 4);

    clr = 1; step(); clr = 0;
    check("clr_fault_clear", 32'(fault), 0);
    check("clr_sp0", 32'(sp_level), 0);
    pc_in = 8'h60; ret = 1;
    #1 check("udf_npc", 32'(next_pc), 32'h60);
    step(); idle();
    check("udf_fault", 32'(fault), 1);
    check("udf_sp0", 32'(sp_level), 0);

    clr = 1; step(); clr = 0;
    do_call(8'h21, 8'h22, 8'h22);
    pc_in = 8'h22; halt = 1; ret = 1;
    #1 check("halt_npc", 32'(next_pc), 32'h22);
    step(); idle();
    check("halt_flag", 32'(halted), 1);
    check("halt_no_pop", 32'(sp_level), 1);
    for (int i = 0; i < 5; i++) begin
      pc_in = 8'h22; call = (i % 2 == 0); jump = 1; target = 8'hC0; ret = (i % 2 == 1);
      #1 check("halt_hold_npc", 32'(next_pc), 32'h22);
      step(); idle();
      check("halt_hold_sp", 32'(sp_level), 1);
    end
    check("halt_still", 32'(halted), 1);
    clr = 1; step(); clr = 0;
    check("halt_clr_run", 32'(halted), 0);
    check("halt_clr_sp", 32'(sp_level), 0);
    pc_in = 8'h07;
    #1 check("run_after_clr", 32'(next_pc), 32'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
